dp_regfile_param: RTL
=====================

// Module: dp_regfile_param
// PURPOSE
//  Parametrised dual-port register file: one write port and one read port, both on clk.
//  Successor to the fixed 16x16 negedge SRAM. Adds:
//   - generic width/depth, optional hardwired-zero entry 0
//   - a hardware clear sequencer, replacing file-based init
//   - write-first bypass, 1- or 2-cycle read latency with rvalid
//  Sits between CPU decode/writeback and the datapath; also usable as a small scratch RAM.
// PARAMETERS
//  DATA_W    16  entry width in bits
//  ADDR_W    4   address width; DEPTH = 2**ADDR_W entries
//  ZERO_REG0 1   1: entry 0 reads as 0 and writes to it are dropped; 0: ordinary entry
//  READ_LAT  1   read latency in cycles, 1 or 2; any other value is an elaboration $error
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst_n       in   1       asynchronous active-low reset
//  clr         in   1       pulse: start a clear sequence (zero all entries)
//  we          in   1       write enable
//  waddr       in   ADDR_W  write address
//  wdata       in   DATA_W  write data
//  re          in   1       read enable
//  raddr       in   ADDR_W  read address
//  rdata       out  DATA_W  read data, registered
//  rvalid      out  1       rdata updated by a read this cycle
//  init_busy   out  1       clear sequence in progress; port requests ignored
//  hlt         in   1       halt indicator, used only for the debug dump
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - rdata=0, rvalid=0, init_busy=1, clear pointer=0, read pipeline flushed, FSM=CLEAR.
//   - Array contents are not touched by reset itself.
//  FSM states: CLEAR, READY.
//   - CLEAR: one entry per cycle, mem[ptr]<=0, ptr++. After ptr==DEPTH-1 -> READY.
//     So init_busy is high for exactly DEPTH cycles after rst_n rises.
//   - READY: clr=1 -> CLEAR with ptr=0; init_busy rises the next cycle.
//  In CLEAR:
//   - we, re and clr are ignored; no write, no rvalid.
//   - rst_n low mid-clear restarts the clear from ptr=0.
//  Write (READY, we=1):
//   - mem[waddr]<=wdata at posedge.
//   - Dropped when ZERO_REG0=1 and waddr=0.
//  Read (READY, re=1), data path:
//   - Samples mem[raddr] at posedge.
//   - If we=1 and waddr==raddr the same cycle, returns wdata (write-first bypass).
//   - Exception: raddr=0 with ZERO_REG0=1 always returns 0.
//  Read timing:
//   - READ_LAT=1: rdata/rvalid valid the cycle after the re edge.
//   - READ_LAT=2: one extra output register stage; valid two cycles after.
//   - Fully pipelined: back-to-back reads every cycle.
//   - rvalid is a 1-cycle pulse per read; rdata holds its last value when no read completes.
//  Read vs clear:
//   - Reads issued in READY before a clr complete normally with pre-clear data.
//   - clr in the same cycle as re/we: the access is performed, then CLEAR starts.
//   - clr asserted while already in CLEAR has no effect.
//  Address range: waddr/raddr span exactly DEPTH entries; no out-of-range case exists.
// CONFIGURATION
//  RF_DUMP_EN defined:
//   - On posedge hlt, $display every entry as "R%0h = %h", from index (ZERO_REG0 ? 1 : 0)
//     to DEPTH-1. Simulation only; no synthesised logic.
//  RF_DUMP_EN undefined:
//   - hlt is unused; no display code is compiled; functional behaviour is identical.
// TESTING
//  1. Clear after reset: release rst_n, poll init_busy
//     -> high exactly 2**ADDR_W cycles (16 at default), then 0; read all entries -> 0x0000.
//  2. Write/read, READ_LAT=1: write 0xBEEF@3, then re raddr=3
//     -> rdata=0xBEEF with rvalid=1 one cycle later. Repeat with READ_LAT=2: latency 2.
//  3. Bypass and zero entry:
//     - same cycle we addr5=0x1234 and re addr5 -> rdata=0x1234.
//     - write 0xFFFF@0 then read 0 -> 0x0000 (ZERO_REG0=1); 0xFFFF with ZERO_REG0=0.
//  4. Clear mid-run:
//     - fill all entries with 0xA5A5, pulse clr -> init_busy high 16 cycles.
//     - we/re during it ignored (rvalid stays 0); afterwards every entry reads 0.
//  5. Async reset mid-clear: drop rst_n at clear cycle 7, release
//     -> rdata=0, rvalid=0 immediately; init_busy high another full 16 cycles.
//  6. RF_DUMP_EN: write distinct values, raise hlt
//     -> 15 lines R1..Rf printed with matching values; no output when the macro is undefined.

Source files
------------

// File: rtl/dp_regfile_param.sv
// Parametrised 1W/1R register file with a hardware clear sequencer, write-first bypass
// and 1- or 2-cycle registered reads. Define RF_DUMP_EN to print the array on posedge hlt.
module dp_regfile_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int ZERO_REG0 = 1,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              init_busy,
  input  logic              hlt
);

  localparam int DEPTH = 1 << ADDR_W;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("dp_regfile_param: READ_LAT must be 1 or 2, got %0d", READ_LAT);
  end

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready;
  logic              wr_drop;
  logic              rd_zero;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;

  assign ready     = (state == READY);
  assign init_busy = (state == CLEAR);
  assign wr_drop   = (ZERO_REG0 != 0) && (waddr == '0);
  assign rd_zero   = (ZERO_REG0 != 0) && (raddr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (!ready)
        ptr <= ptr + 1'b1;
      else if (clr)
        ptr <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (ptr == '1) state_nxt = READY;
      READY:   if (clr)       state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // Array has no reset; the clear sequencer is the only way it gets zeroed.
  always_ff @(posedge clk) begin
    if (!ready)
      mem[ptr] <= '0;
    else if (we && !wr_drop)
      mem[waddr] <= wdata;
  end

  always_comb begin
    rd_word = mem[raddr];
    if (rd_zero)
      rd_word = '0;
    else if (we && (waddr == raddr))
      rd_word = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= ready && re;
      if (ready && re)
        s1_data <= rd_word;
    end
  end

  // Second stage keeps draining during CLEAR so reads issued before a clr still complete.
  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid)
          s2_data <= s1_data;
      end
    end

    assign rdata  = s2_data;
    assign rvalid = s2_valid;
  end else begin : g_lat1
    assign rdata  = s1_data;
    assign rvalid = s1_valid;
  end

`ifdef RF_DUMP_EN
  always @(posedge hlt) begin
    for (int i = (ZERO_REG0 != 0) ? 1 : 0; i < DEPTH; i++)
      $display("R%0h = %h", i, mem[i]);
  end
`else
  logic unused_hlt;
  assign unused_hlt = hlt;
`endif

endmodule
